vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator and pixel output stage. It is the successor to the fixed 640x480 controller.
- Timing, sync polarity, colour depth and pixel-fetch pipeline latency are set by parameters.
- A pixel-clock enable allows running from a faster system clock.
- It issues pixel requests ahead of time so that upstream frame-buffer or renderer latency is absorbed.
- It sits between the pixel source (frame buffer or renderer) and the resistor-DAC VGA connector.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the timing generator (master) and the pixel source (slave).
// The source answers each request on color_in PIPE_LAT enabled cycles later.
interface vga_timing_gen_if #(
  parameter int CW = 8
);
  logic [10:0]     req_x;
  logic [9:0]      req_y;
  logic            req_valid;
  logic [3*CW-1:0] color_in;

  modport master (output req_x, req_y, req_valid, input color_in);
  modport slave  (input req_x, req_y, req_valid, output color_in);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a latency-matched pixel output stage.
// Optional colour-bar generator enabled by defining VGA_TESTPAT_EN (adds port test_mode).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
`ifdef VGA_TESTPAT_EN
  input  logic             test_mode,
`endif
  vga_timing_gen_if.master pix,
  output logic             hsync,
  output logic             vsync,
  output logic [CW-1:0]    red,
  output logic [CW-1:0]    green,
  output logic [CW-1:0]    blue,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt,
  output logic             vga_clk,
  output logic             vga_sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_PULSE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic        H_ON       = 1'(H_POL);
  localparam logic        V_ON       = 1'(V_POL);

`ifdef VGA_TESTPAT_EN
  // Pipeline word also carries the bar index so the pattern stays aligned with sync.
  localparam int          PW    = 6;
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  function automatic logic [3*CW-1:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] on;
    case (bar)
      3'd0:    on = 3'b111;
      3'd1:    on = 3'b110;
      3'd2:    on = 3'b011;
      3'd3:    on = 3'b010;
      3'd4:    on = 3'b101;
      3'd5:    on = 3'b100;
      3'd6:    on = 3'b001;
      3'd7:    on = 3'b000;
      default: on = 3'b000;
    endcase
    return {{CW{on[2]}}, {CW{on[1]}}, {CW{on[0]}}};
  endfunction
`else
  localparam int PW = 3;
`endif

  logic [10:0]     h_cnt_r;
  logic [9:0]      v_cnt_r;
  logic            active_s;
  logic            hs_s;
  logic            vs_s;
  logic [PW-1:0]   fetch_s;
  logic [PW-1:0]   dly_s;
  logic [3*CW-1:0] pix_rgb_s;

  // Raster counters and completed-frame count, all frozen while en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt_r   <= 11'd0;
      v_cnt_r   <= 10'd0;
      frame_cnt <= 16'd0;
    end else if (en) begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= 11'd0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r   <= 10'd0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 11'd1;
      end
    end
  end

  // Fetch-side decode and the request bus toward the pixel source.
  always_comb begin
    active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    hs_s     = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
    vs_s     = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);
    pix.req_valid = active_s;
    if (active_s) begin
      pix.req_x = h_cnt_r;
      pix.req_y = v_cnt_r;
    end else begin
      pix.req_x = 11'd0;
      pix.req_y = 10'd0;
    end
  end

`ifdef VGA_TESTPAT_EN
  assign fetch_s = {3'(h_cnt_r / BAR_W), vs_s, hs_s, active_s};
`else
  assign fetch_s = {vs_s, hs_s, active_s};
`endif

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign dly_s = fetch_s;
    end else begin : g_pipe
      logic [PW-1:0] stage_r [PIPE_LAT];

      // Delay the decode by the pixel source latency, stepping only on en.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) stage_r[i] <= {PW{1'b0}};
        end else if (en) begin
          stage_r[0] <= fetch_s;
          for (int i = 1; i < PIPE_LAT; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign dly_s = stage_r[PIPE_LAT-1];
    end
  endgenerate

  // Colour selection for the pixel leaving the pipeline; blanked outside active video.
  always_comb begin
    pix_rgb_s = {3*CW{1'b0}};
    if (dly_s[0]) begin
`ifdef VGA_TESTPAT_EN
      if (test_mode) begin
        pix_rgb_s = bar_rgb(dly_s[5:3]);
      end else begin
        pix_rgb_s = pix.color_in;
      end
`else
      pix_rgb_s = pix.color_in;
`endif
    end else begin
      pix_rgb_s = {3*CW{1'b0}};
    end
  end

  // Registered video outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync              <= ~H_ON;
      vsync              <= ~V_ON;
      blank_n            <= 1'b0;
      {red, green, blue} <= {3*CW{1'b0}};
    end else if (en) begin
      hsync              <= dly_s[1] ? H_ON : ~H_ON;
      vsync              <= dly_s[2] ? V_ON : ~V_ON;
      blank_n            <= dly_s[0];
      {red, green, blue} <= pix_rgb_s;
    end
  end

  // Start pulses; gating with en keeps them one clock wide under a sparse enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en && (h_cnt_r == 11'd0) && (v_cnt_r < V_ACT_C);
      frame_start <= en && (h_cnt_r == 11'd0) && (v_cnt_r == 10'd0);
    end
  end

  assign vga_clk    = clock;
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two reduced-size generators (latency 2 / active-low, latency 0 / active-high)
// compared cycle by cycle against a model built from the enabled-cycle index.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HP = 3, HB = 2;
  localparam int VA = 8, VF = 1, VP = 2, VB = 2;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT_A = 2, LAT_B = 0;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [23:0] rgb;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset, en, test_mode;
  always #5 clock = ~clock;

  vga_timing_gen_if #(.CW(8)) pa ();
  vga_timing_gen_if #(.CW(8)) pb ();

  logic       a_hsync, a_vsync, a_blank_n, a_ls, a_fs, a_vclk, a_sync_n;
  logic [7:0] a_r, a_g, a_b;
  logic [15:0] a_fc;
  logic       b_hsync, b_vsync, b_blank_n, b_ls, b_fs, b_vclk, b_sync_n;
  logic [7:0] b_r, b_g, b_b;
  logic [15:0] b_fc;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
                   .H_POL(0), .V_POL(0), .PIPE_LAT(LAT_A), .CW(8)) dut_a (
    .clock(clock), .reset(reset), .en(en),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pix(pa), .hsync(a_hsync), .vsync(a_vsync), .red(a_r), .green(a_g), .blue(a_b),
    .blank_n(a_blank_n), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc),
    .vga_clk(a_vclk), .vga_sync_n(a_sync_n));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
                   .H_POL(1), .V_POL(1), .PIPE_LAT(LAT_B), .CW(8)) dut_b (
    .clock(clock), .reset(reset), .en(en),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pix(pb), .hsync(b_hsync), .vsync(b_vsync), .red(b_r), .green(b_g), .blue(b_b),
    .blank_n(b_blank_n), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc),
    .vga_clk(b_vclk), .vga_sync_n(b_sync_n));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   k;
  int   stop_at;
  exp_t ea, eb;

  // Raster position of the idx-th enabled cycle since reset release.
  function automatic int px(int idx); return idx % HT; endfunction
  function automatic int py(int idx); return (idx / HT) % VT; endfunction
  function automatic bit is_act(int idx); return (px(idx) < HA) && (py(idx) < VA); endfunction
  function automatic bit in_hs(int idx); return (px(idx) >= HA + HF) && (px(idx) < HA + HF + HP); endfunction
  function automatic bit in_vs(int idx); return (py(idx) >= VA + VF) && (py(idx) < VA + VF + VP); endfunction
  function automatic logic [23:0] pix_of(int idx);
    return {8'(px(idx)), 8'(py(idx)), 8'hA5};
  endfunction

  function automatic logic [23:0] bar_of(int idx);
    case (px(idx) / (HA / 8))
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t rst_exp(bit hp, bit vp);
    exp_t e;
    e.hsync = ~hp; e.vsync = ~vp; e.blank_n = 1'b0; e.rgb = 24'h0;
    e.ls = 1'b0; e.fs = 1'b0; e.fc = 16'd0;
    return e;
  endfunction

  function automatic exp_t video(exp_t prev, int kk, int lat, bit hp, bit vp, bit tm);
    exp_t e = prev;
    int idx = kk - lat;
    if (idx < 0) begin
      e.hsync = ~hp; e.vsync = ~vp; e.blank_n = 1'b0; e.rgb = 24'h0;
    end else begin
      e.hsync   = in_hs(idx) ? hp : ~hp;
      e.vsync   = in_vs(idx) ? vp : ~vp;
      e.blank_n = is_act(idx);
      e.rgb     = !is_act(idx) ? 24'h0 : (tm ? bar_of(idx) : pix_of(idx));
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, expv);
    end
  endtask

  task automatic check_req(input string n, input logic [10:0] x, input logic [9:0] y, input logic v);
    bit act = is_act(k);
    chk({n, "_req_x"}, 32'(x), act ? 32'(px(k)) : 32'd0);
    chk({n, "_req_y"}, 32'(y), act ? 32'(py(k)) : 32'd0);
    chk({n, "_req_valid"}, 32'(v), 32'(act));
  endtask

  task automatic check_out(input string n, input exp_t e, input logic hs, input logic vs,
                           input logic bl, input logic [23:0] rgb, input logic ls,
                           input logic fs, input logic [15:0] fc, input logic sn, input logic vc);
    chk({n, "_hsync"}, 32'(hs), 32'(e.hsync));
    chk({n, "_vsync"}, 32'(vs), 32'(e.vsync));
    chk({n, "_blank_n"}, 32'(bl), 32'(e.blank_n));
    chk({n, "_rgb"}, 32'(rgb), 32'(e.rgb));
    chk({n, "_line_start"}, 32'(ls), 32'(e.ls));
    chk({n, "_frame_start"}, 32'(fs), 32'(e.fs));
    chk({n, "_frame_cnt"}, 32'(fc), 32'(e.fc));
    chk({n, "_sync_n"}, 32'(sn), 32'd0);
    chk({n, "_vga_clk"}, 32'(vc), 32'(clock));
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input logic r, input logic e);
    logic ls_e, fs_e;
    reset = r;
    en    = e;
    pa.color_in = (k >= LAT_A && is_act(k - LAT_A)) ? pix_of(k - LAT_A) : 24'($urandom);
    pb.color_in = is_act(k - LAT_B) ? pix_of(k - LAT_B) : 24'($urandom);
    @(posedge clock);
    if (r) begin
      k  = 0;
      ea = rst_exp(1'b0, 1'b0);
      eb = rst_exp(1'b1, 1'b1);
    end else if (e) begin
      ea   = video(ea, k, LAT_A, 1'b0, 1'b0, test_mode);
      eb   = video(eb, k, LAT_B, 1'b1, 1'b1, test_mode);
      ls_e = (px(k) == 0) && (py(k) < VA);
      fs_e = (px(k) == 0) && (py(k) == 0);
      k++;
      ea.ls = ls_e; ea.fs = fs_e; ea.fc = 16'(k / FRAME);
      eb.ls = ls_e; eb.fs = fs_e; eb.fc = 16'(k / FRAME);
    end else begin
      ea.ls = 1'b0; ea.fs = 1'b0;
      eb.ls = 1'b0; eb.fs = 1'b0;
    end
    @(negedge clock);
    check_req("a", pa.req_x, pa.req_y, pa.req_valid);
    check_req("b", pb.req_x, pb.req_y, pb.req_valid);
    check_out("a", ea, a_hsync, a_vsync, a_blank_n, {a_r, a_g, a_b}, a_ls, a_fs, a_fc, a_sync_n, a_vclk);
    check_out("b", eb, b_hsync, b_vsync, b_blank_n, {b_r, b_g, b_b}, b_ls, b_fs, b_fc, b_sync_n, b_vclk);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; test_mode = 1'b0; k = 0;
    pa.color_in = 24'h0; pb.color_in = 24'h0;
    ea = rst_exp(1'b0, 1'b0);
    eb = rst_exp(1'b1, 1'b1);

    repeat (5) step(1'b1, 1'b1);
    chk("rst_hsync_idle_high", 32'(a_hsync), 32'd1);
    step(1'b0, 1'b1);
    chk("first_frame_start", 32'(a_fs), 32'd1);
    step(1'b0, 1'b1);
    chk("frame_start_one_clock", 32'(a_fs), 32'd0);

    repeat (2 * FRAME) step(1'b0, 1'b1);
    chk("frame_cnt_after_two", 32'(a_fc), 32'd2);

    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'((i % 2) == 0));

    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 1'($urandom_range(0, 3) == 0));

    repeat (3) begin
      stop_at = int'($urandom_range(HT * 2, FRAME - 1));
      for (int j = 0; j < FRAME && (k % FRAME) != stop_at; j++) step(1'b0, 1'b1);
      step(1'b1, 1'($urandom_range(0, 1)));
      chk("midframe_rst_frame_cnt", 32'(b_fc), 32'd0);
      chk("midframe_rst_req_x", 32'(pa.req_x), 32'd0);
      step(1'b0, 1'b1);
      chk("restart_frame_start", 32'(b_fs), 32'd1);
    end

    repeat (FRAME + 7) step(1'b0, 1'b1);

`ifdef VGA_TESTPAT_EN
    test_mode = 1'b1;
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 1'($urandom_range(0, 1)));
    test_mode = 1'b0;
    repeat (HT) step(1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
